cac_decoder_7: RTL

CAC_DECODER_7 -- requirements
Module: cac_decoder_7

---
 rtl/cac_fns_pkg.sv | 19 +
 rtl/cac_fns_weight.sv | 21 ++
 rtl/cac_decoder_7.sv | 99 +++++++++
 3 files changed

// File: rtl/cac_fns_pkg.sv
// Shared constants and types for the FNS-weighted CAC decoder.
// Holds Fibonacci bit weights, width defaults and the FSM state type.
package cac_fns_pkg;

  localparam int unsigned CODE_W_DEF = 7;
  localparam int unsigned DATA_W_DEF = 5;
  localparam int unsigned ACC_W_DEF  = 6;

  // Weight of codeword bit i, index 0 first.
  localparam int unsigned FNS_WEIGHT [CODE_W_DEF] =
    '{1, 1, 2, 3, 5, 8, 13};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } cac_state_t;

endpackage

// File: rtl/cac_fns_weight.sv
// Combinational bit-index to FNS weight lookup.
// Indices beyond the weight table map to zero.
module cac_fns_weight
  import cac_fns_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  output logic [ACC_W-1:0] weight
);

  // Table lookup, guarded against out-of-range indices.
  always_comb begin
    weight = '0;
    if (int'(idx) < int'(CODE_W_DEF)) begin
      weight = ACC_W'(FNS_WEIGHT[idx]);
    end
  end

endmodule

// File: rtl/cac_decoder_7.sv
// Serial FNS-weighted CAC decoder, one codeword bit per cycle, MSB first.
// Optional CACDEC_ERRCHK_EN: flag results that overflow DATA_W bits.
module cac_decoder_7
  import cac_fns_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] codein,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              err
);

  localparam int IDX_W = $clog2(CODE_W);

  cac_state_t        state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [CODE_W-1:0] shadow, shadow_nxt;
  logic [ACC_W-1:0]  weight;

  cac_fns_weight #(
    .ACC_W(ACC_W),
    .IDX_W(IDX_W)
  ) u_weight (
    .idx   (idx),
    .weight(weight)
  );

  // State and datapath registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      idx    <= '0;
      shadow <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      idx    <= idx_nxt;
      shadow <= shadow_nxt;
    end
  end

  // Next-state: capture, accumulate MSB first, then hold until taken.
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    idx_nxt    = idx;
    shadow_nxt = shadow;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          shadow_nxt = codein;
          acc_nxt    = '0;
          idx_nxt    = IDX_W'(CODE_W - 1);
          state_nxt  = ACC;
        end
      end
      ACC: begin
        if (shadow[idx]) begin
          acc_nxt = acc + weight;
        end
        if (idx == '0) begin
          state_nxt = DONE;
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags and result; the result reads zero outside DONE.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    dataout   = out_valid ? DATA_W'(acc) : '0;
`ifdef CACDEC_ERRCHK_EN
    err = out_valid &&
          (acc > ACC_W'((2 ** DATA_W) - 1));
`else
    err = 1'b0;
`endif
  end

endmodule
